// File: rtl/uart_cmd_decoder.sv
// Text command decoder behind a UART receiver: parses "<letter>[digit]<CR|LF>"
// lines and replays the selected action as a train of spaced one-cycle pulses.
module uart_cmd_decoder #(
    parameter int unsigned GAP_CYCLES     = 27000,
    parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [4:0] action,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        GOT_CMD,
        GOT_ARG,
        EXEC,
        DISCARD
    } state_t;

    typedef enum logic [1:0] {
        ERR_OVERRUN = 2'd0,
        ERR_UNKNOWN = 2'd1,
        ERR_BAD_ARG = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam int SLEEP_BIT = 3;

    state_t           state, state_d;
    logic [4:0]       cmd, cmd_d;
    logic [3:0]       count, count_d;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_d;
    logic [CNT_W-1:0] to_cnt, to_cnt_d;
    logic [4:0]       action_d;
    logic             busy_d;
    logic             err_d;
    logic [1:0]       err_code_d;

    logic       is_term;
    logic       is_digit;
    logic [4:0] cmd_hit;
    logic       is_cmd;
    logic       timeout_hit;
    logic       gap_done;

    // Byte classification; OR-ing in 0x20 folds upper case onto lower case.
    always_comb begin
        is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
        is_digit = (rx_byte >= 8'h31) && (rx_byte <= 8'h39);
        unique case (rx_byte | 8'h20)
            8'h66:   cmd_hit = 5'b00001;
            8'h70:   cmd_hit = 5'b00010;
            8'h63:   cmd_hit = 5'b00100;
            8'h73:   cmd_hit = 5'b01000;
            8'h6D:   cmd_hit = 5'b10000;
            default: cmd_hit = 5'b00000;
        endcase
        is_cmd      = |cmd_hit;
        timeout_hit = !rx_valid && ((to_cnt + CNT_W'(1)) == TO_LIM);
        gap_done    = (gap_cnt == GAP_LIM);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= '0;
            count    <= '0;
            gap_cnt  <= '0;
            to_cnt   <= '0;
            action   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_OVERRUN;
        end else begin
            state    <= state_d;
            cmd      <= cmd_d;
            count    <= count_d;
            gap_cnt  <= gap_cnt_d;
            to_cnt   <= to_cnt_d;
            action   <= action_d;
            busy     <= busy_d;
            err      <= err_d;
            err_code <= err_code_d;
        end
    end

    // NOTE: every signal driven in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (rx_valid && !is_term)
                    state_d = is_cmd ? GOT_CMD : DISCARD;
            end
            GOT_CMD: begin
                if (rx_valid) begin
                    if (is_term)
                        state_d = EXEC;
                    else if (is_digit && !cmd[SLEEP_BIT])
                        state_d = GOT_ARG;
                    else
                        state_d = DISCARD;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            GOT_ARG: begin
                if (rx_valid)
                    state_d = is_term ? EXEC : DISCARD;
                else if (timeout_hit)
                    state_d = IDLE;
            end
            EXEC: begin
                if (count == 4'd0)
                    state_d = IDLE;
            end
            DISCARD: begin
                if ((rx_valid && is_term) || timeout_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_d      = cmd;
        count_d    = count;
        gap_cnt_d  = gap_cnt;
        to_cnt_d   = '0;
        action_d   = '0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code;

        // Inter-byte timer runs only while a line is partially received.
        if (state == GOT_CMD || state == GOT_ARG || state == DISCARD) begin
            if (!rx_valid && !timeout_hit)
                to_cnt_d = to_cnt + CNT_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (rx_valid && !is_term) begin
                    if (is_cmd) begin
                        cmd_d   = cmd_hit;
                        count_d = 4'd1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_UNKNOWN;
                    end
                end
            end
            GOT_CMD, GOT_ARG: begin
                if (rx_valid) begin
                    if (is_term) begin
                        // First pulse leaves with the terminator; count holds the rest.
                        action_d  = cmd;
                        busy_d    = 1'b1;
                        count_d   = count - 4'd1;
                        gap_cnt_d = '0;
                    end else if (state == GOT_CMD && is_digit && !cmd[SLEEP_BIT]) begin
                        count_d = rx_byte[3:0];
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_ARG;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            EXEC: begin
                if (rx_valid) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (count == 4'd0) begin
                    gap_cnt_d = '0;
                end else begin
                    busy_d = 1'b1;
                    if (gap_done) begin
                        action_d  = cmd;
                        count_d   = count - 4'd1;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt + CNT_W'(1);
                    end
                end
            end
            DISCARD: ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with GAP_CYCLES=4, TIMEOUT_CYCLES=100:
// a per-cycle vector table plus hand sequences for pulse trains and timeouts.
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [4:0] action;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;

    uart_cmd_decoder #(
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .action  (action),
        .busy    (busy),
        .err     (err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [4:0] act;
        logic       bsy;
        logic       er;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic v, input logic [4:0] act,
                                input logic bsy, input logic er, input logic [1:0] code);
        vec_t r;
        r.b = b; r.v = v; r.act = act; r.bsy = bsy; r.er = er; r.code = code;
        return r;
    endfunction

    initial begin
        int pulses;
        int errs;

        // byte, valid, expected action, busy, err, err_code after the edge
        vecs.push_back(mk("F",   1, 5'b00001 & 5'b0, 0, 0, 0));
        vecs.push_back(mk(8'h0D, 1, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(8'h00, 0, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h00, 0, 5'b00000, 0, 0, 0));
        vecs.push_back(mk("X",   1, 5'b00000, 0, 1, 1));
        vecs.push_back(mk("5",   1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk(8'h0D, 1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("S",   1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("2",   1, 5'b00000, 0, 1, 2));
        vecs.push_back(mk(8'h0D, 1, 5'b00000, 0, 0, 2));
        vecs.push_back(mk("M",   1, 5'b00000, 0, 0, 2));
        vecs.push_back(mk(8'h0A, 1, 5'b10000, 1, 0, 2));
        vecs.push_back(mk(8'h00, 0, 5'b00000, 0, 0, 2));
        vecs.push_back(mk(8'h0A, 1, 5'b00000, 0, 0, 2));
        vecs.push_back(mk("c",   1, 5'b00000, 0, 0, 2));
        vecs.push_back(mk("0",   1, 5'b00000, 0, 1, 2));
        vecs.push_back(mk(8'h0D, 1, 5'b00000, 0, 0, 2));
        vecs.push_back(mk(8'h00, 1, 5'b00000, 0, 1, 1));
        vecs.push_back(mk(8'h0A, 1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("m",   1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("1",   1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk(8'h0D, 1, 5'b10000, 1, 0, 1));
        vecs.push_back(mk(8'h00, 0, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("f",   1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("2",   1, 5'b00000, 0, 0, 1));
        vecs.push_back(mk("x",   1, 5'b00000, 0, 1, 2));
        vecs.push_back(mk(8'h0D, 1, 5'b00000, 0, 0, 2));

        // Reset, with a command byte coinciding with rst that must be dropped.
        rst      = 1'b1;
        rx_byte  = "F";
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        check("reset action", 32'(action), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset err", 32'(err), 32'(0));
        check("reset err_code", 32'(err_code), 32'(0));
        rst = 1'b0;
        send(8'h0D);
        check("byte during rst dropped", 32'(action), 32'(0));
        step();

        foreach (vecs[i]) begin
            rx_byte  = vecs[i].b;
            rx_valid = vecs[i].v;
            step();
            rx_valid = 1'b0;
            check($sformatf("vec[%0d] action", i), 32'(action), 32'(vecs[i].act));
            check($sformatf("vec[%0d] busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("vec[%0d] err", i), 32'(err), 32'(vecs[i].er));
            check($sformatf("vec[%0d] err_code", i), 32'(err_code), 32'(vecs[i].code));
        end

        // "p3\n": pulses at T+1, T+6, T+11; busy T+1..T+11.
        send("p");
        send("3");
        send(8'h0A);
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("p3 action T+%0d", c), 32'(action),
                  32'((c == 1 || c == 6 || c == 11) ? 5'b00010 : 5'b00000));
            check($sformatf("p3 busy T+%0d", c), 32'(busy), 32'(c <= 11));
            step();
        end

        // "C" then 100 idle cycles: exactly one timeout error on the 100th.
        send("C");
        for (int i = 1; i <= 100; i++) begin
            step();
            check($sformatf("timeout err idle %0d", i), 32'(err), 32'(i == 100));
        end
        check("timeout err_code", 32'(err_code), 32'(3));
        step();
        check("timeout err one cycle", 32'(err), 32'(0));
        send("C");
        send(8'h0D);
        check("C after timeout", 32'(action), 32'(5'b00100));
        step();

        // Byte arriving exactly when the count is reached wins over the timeout.
        send("C");
        errs = 0;
        for (int i = 1; i <= 99; i++) begin
            step();
            errs += int'(err);
        end
        send(8'h0D);
        check("late CR errs", 32'(errs), 32'(0));
        check("late CR action", 32'(action), 32'(5'b00100));
        check("late CR err", 32'(err), 32'(0));
        step();

        // DISCARD times out silently back to IDLE.
        send("Z");
        check("Z err_code", 32'(err_code), 32'(1));
        errs = 0;
        for (int i = 1; i <= 105; i++) begin
            step();
            errs += int'(err);
        end
        check("discard timeout silent", 32'(errs), 32'(0));
        send("F");
        send(8'h0D);
        check("F after discard timeout", 32'(action), 32'(5'b00001));
        step();

        // "F9\r", overrun byte during EXEC, reset after the third pulse.
        send("F");
        send("9");
        send(8'h0D);
        pulses = int'(action != 5'b0);
        rx_byte  = "P";
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check("overrun err", 32'(err), 32'(1));
        check("overrun err_code", 32'(err_code), 32'(0));
        check("overrun busy", 32'(busy), 32'(1));
        for (int c = 3; c <= 11; c++) begin
            step();
            pulses += int'(action != 5'b0);
            check($sformatf("F9 action T+%0d", c), 32'(action),
                  32'((c == 6 || c == 11) ? 5'b00001 : 5'b00000));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'(0));
        check("abort action", 32'(action), 32'(0));
        for (int i = 0; i < 20; i++) begin
            step();
            pulses += int'(action != 5'b0);
        end
        check("F9 pulses after abort", 32'(pulses), 32'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter GAP_CYCLES, default 27000, idle cycles between repeated action pulses (1 ms at 27 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 27000000, maximum cycles between bytes of one command line (1 s at 27 MHz).
REQ-003 The block has one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rx_byte  in  8  received byte from the UART receiver.
REQ-007 rx_valid  in  1  rx_byte is valid this cycle; single-cycle strobe.
REQ-008 action  out  5  one-hot action pulse: [0] feed, [1] play, [2] clean, [3] sleep, [4] medicine.
REQ-009 busy  out  1  high while a command is executing.
REQ-010 err  out  1  one-cycle error strobe.
REQ-011 err_code  out  2  cause of the last error: 0 overrun, 1 unknown command, 2 bad argument, 3 timeout; held until the next error.

Function
REQ-012 The grammar SHALL be: command letter, then an optional single digit '1'..'9', then a terminator CR (0x0D) or LF (0x0A).
REQ-013 The command letters SHALL be F, P, C, S and M, mapped to action bits 0..4; the lowercase forms SHALL be accepted as equivalents.
REQ-014 The FSM states SHALL be IDLE, GOT_CMD, GOT_ARG, EXEC and DISCARD.
REQ-015 In IDLE, a terminator byte SHALL be ignored silently; a command letter SHALL latch the action and count=1 and go to GOT_CMD; any other byte, including 0x00, SHALL raise err with code 1 and go to DISCARD.
REQ-016 In GOT_CMD, a terminator SHALL go to EXEC; a digit '1'..'9' SHALL latch the count and go to GOT_ARG; any other byte SHALL raise err with code 2 and go to DISCARD.
REQ-017 S SHALL accept no digit: a digit after S SHALL raise err with code 2 and go to DISCARD.
REQ-018 In GOT_ARG, a terminator SHALL go to EXEC; any other byte SHALL raise err with code 2 and go to DISCARD.
REQ-019 In DISCARD, bytes SHALL be swallowed without further errors until a terminator, which SHALL return the FSM to IDLE.
REQ-020 In GOT_CMD, GOT_ARG and DISCARD, a timeout counter SHALL reset on each rx_valid.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES, GOT_CMD and GOT_ARG SHALL raise err with code 3 and return to IDLE; DISCARD SHALL return to IDLE silently.
REQ-022 Latency: if the terminator is sampled at edge T, the first action pulse and busy SHALL be high in cycle T+1.
REQ-023 Each action pulse SHALL last exactly one cycle, and consecutive pulses SHALL be spaced GAP_CYCLES+1 cycles apart.
REQ-024 For count N, pulses SHALL occur at T+1+k*(GAP_CYCLES+1) for k=0..N-1.
REQ-025 busy SHALL be high from T+1 through the last pulse cycle inclusive and low in the following cycle, when the FSM is back in IDLE.
REQ-026 An rx_valid during EXEC SHALL drop the byte, raise err with code 0, and leave the execution undisturbed.
REQ-027 err SHALL be a registered one-cycle pulse, and err_code SHALL update in the same cycle that err is high.
REQ-028 At most one action bit SHALL be high in any cycle.
REQ-029 The gap and timeout counters SHALL be 25 bits wide and SHALL NOT wrap: each is cleared on use.
REQ-030 rx_valid in the same cycle that the timeout count is reached SHALL be processed as a normal byte, and no timeout SHALL fire.

Reset
REQ-031 rst SHALL force the following values at the next edge: state=IDLE, action=0, busy=0, err=0, err_code=0, all counters=0, latched command cleared.
REQ-032 rst asserted mid-EXEC SHALL abort execution immediately, with no further pulses after the reset edge.
REQ-033 A byte whose rx_valid coincides with rst SHALL be discarded.

Verification (GAP_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-034 "F\r" with terminator at T -> action=00001 only at T+1; busy high only at T+1; err never asserted.
REQ-035 "p3\n" with terminator at T -> action=00010 at T+1, T+6 and T+11; busy high T+1..T+11, low at T+12.
REQ-036 "X5\r" -> err pulse with code 1 on the cycle after 'X'; '5' and CR swallowed; FSM back in IDLE; no action pulses.
REQ-037 "S2\r" -> err code 2 after '2'; no action pulses; a following "M\r" -> action=10000 one cycle after its CR.
REQ-038 "C" then 100 idle cycles -> one err pulse with code 3, FSM back in IDLE; a later "C\r" executes normally.
REQ-039 "F9\r", byte 'P' sent during EXEC, rst asserted after the 3rd pulse -> err code 0 on 'P'; exactly 3 pulses; busy=0 after the reset edge.
